// File: rtl/population_mem_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | lbm_pkg: shared types and constants for the D2Q9 population store.          |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
package lbm_pkg;

  localparam int NUM_DIRS = 9;
  localparam int POP_W    = 8;
  localparam int DENS_W   = 12;

  typedef enum logic [3:0] {
    DIR_C  = 4'd0,
    DIR_E  = 4'd1,
    DIR_N  = 4'd2,
    DIR_W  = 4'd3,
    DIR_S  = 4'd4,
    DIR_NE = 4'd5,
    DIR_NW = 4'd6,
    DIR_SW = 4'd7,
    DIR_SE = 4'd8
  } dir_e;

  localparam logic [POP_W-1:0] W_CENTER_DEF = 8'd114;
  localparam logic [POP_W-1:0] W_AXIS_DEF   = 8'd28;
  localparam logic [POP_W-1:0] W_DIAG_DEF   = 8'd7;

  typedef logic [NUM_DIRS-1:0][POP_W-1:0] pop_vec_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } mem_state_e;

  // Equilibrium weight for a lane: rest, axis-aligned or diagonal direction.
  function automatic logic [POP_W-1:0] init_weight(
    input int               lane,
    input logic [POP_W-1:0] center,
    input logic [POP_W-1:0] axis,
    input logic [POP_W-1:0] diag
  );
    if (lane == int'(DIR_C))
      return center;
    else if (lane <= int'(DIR_S))
      return axis;
    else
      return diag;
  endfunction

endpackage
`default_nettype wire

// File: rtl/population_mem_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | population_mem_if: init, engine (port A) and display (port B) signals.      |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
interface population_mem_if
  import lbm_pkg::*;
#(
  parameter int AW = 16
) ();

  logic                          init_start_in;
  logic                          init_busy_out;
  logic                          init_done_out;

  logic [NUM_DIRS-1:0][AW-1:0]   eng_addr_in;
  pop_vec_t                      eng_data_in;
  logic                          eng_we_in;
  pop_vec_t                      eng_data_out;

  logic                          disp_valid_in;
  logic [AW-1:0]                 disp_addr_in;
  logic                          disp_valid_out;
  pop_vec_t                      disp_data_out;
  logic [DENS_W-1:0]             disp_density_out;

  logic                          oob_err_out;

  modport slave (
    input  init_start_in, eng_addr_in, eng_data_in, eng_we_in,
           disp_valid_in, disp_addr_in,
    output init_busy_out, init_done_out, eng_data_out,
           disp_valid_out, disp_data_out, disp_density_out, oob_err_out
  );

  modport master (
    output init_start_in, eng_addr_in, eng_data_in, eng_we_in,
           disp_valid_in, disp_addr_in,
    input  init_busy_out, init_done_out, eng_data_out,
           disp_valid_out, disp_data_out, disp_density_out, oob_err_out
  );

endinterface
`default_nettype wire

// File: rtl/population_mem_lane.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pop_bram_lane: one 8-bit population lane, port A r/w, port B read-only,     |
// | read-first with a two-cycle registered read on both ports.                  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module pop_bram_lane
  import lbm_pkg::*;
#(
  parameter int DEPTH = 57600,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_we,
  input  logic [AW-1:0]    a_addr,
  input  logic [POP_W-1:0] a_wdata,
  output logic [POP_W-1:0] a_rdata,
  input  logic [AW-1:0]    b_addr,
  output logic [POP_W-1:0] b_rdata
);

  logic [POP_W-1:0] mem [DEPTH];
  logic [POP_W-1:0] a_stage;
  logic [POP_W-1:0] b_stage;

  // Storage stays unreset so it maps onto block RAM; reads see pre-write data.
  always_ff @(posedge clk) begin
    if (a_we)
      mem[a_addr] <= a_wdata;
    a_stage <= mem[a_addr];
    b_stage <= mem[b_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_rdata <= a_stage;
      b_rdata <= b_stage;
    end
  end

endmodule
`default_nettype wire

// File: rtl/population_mem.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | population_mem: nine-lane D2Q9 population store with init fill, engine      |
// | port and pipelined display/density port. Option: POP_MEM_OOB_CHECK_EN.      |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module population_mem
  import lbm_pkg::*;
#(
  parameter int               HPIXELS     = 320,
  parameter int               VPIXELS     = 180,
  parameter logic [POP_W-1:0] INIT_CENTER = W_CENTER_DEF,
  parameter logic [POP_W-1:0] INIT_AXIS   = W_AXIS_DEF,
  parameter logic [POP_W-1:0] INIT_DIAG   = W_DIAG_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  population_mem_if.slave   bus
);

  localparam int            DEPTH     = HPIXELS * VPIXELS;
  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  mem_state_e                  state;
  logic [AW-1:0]               fill_cnt;
  logic                        init_busy_q;
  logic                        init_done_q;

  logic [NUM_DIRS-1:0]         lane_we;
  logic [NUM_DIRS-1:0][AW-1:0] lane_addr;
  pop_vec_t                    lane_wdata;
  pop_vec_t                    lane_a_rdata;
  pop_vec_t                    lane_b_rdata;

  logic [NUM_DIRS-1:0]         addr_ok;
  logic                        disp_ok;
  logic                        disp_req;
  logic [1:0]                  disp_vld_pipe;
  logic                        disp_valid_q;
  pop_vec_t                    disp_data_q;
  logic [DENS_W-1:0]           dens_sum;
  logic [DENS_W-1:0]           disp_dens_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= ST_IDLE;
      fill_cnt    <= '0;
      init_busy_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      init_done_q <= 1'b0;
      case (state)
        ST_IDLE, ST_RUN: begin
          if (bus.init_start_in) begin
            state       <= ST_INIT;
            fill_cnt    <= '0;
            init_busy_q <= 1'b1;
          end
        end
        ST_INIT: begin
          if (fill_cnt == LAST_ADDR) begin
            state       <= ST_RUN;
            fill_cnt    <= '0;
            init_busy_q <= 1'b0;
            init_done_q <= 1'b1;
          end else begin
            fill_cnt <= fill_cnt + AW'(1);
          end
        end
        default: begin
          state       <= ST_IDLE;
          init_busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef POP_MEM_OOB_CHECK_EN
  localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);

  logic oob_event;
  logic oob_err_q;

  always_comb begin
    for (int i = 0; i < NUM_DIRS; i++)
      addr_ok[i] = ({1'b0, bus.eng_addr_in[i]} < DEPTH_EXT);
    disp_ok   = ({1'b0, bus.disp_addr_in} < DEPTH_EXT);
    oob_event = (state == ST_RUN) &&
                ((bus.eng_we_in && !(&addr_ok)) || (bus.disp_valid_in && !disp_ok));
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      oob_err_q <= 1'b0;
    else if (oob_event)
      oob_err_q <= 1'b1;
  end

  assign bus.oob_err_out = oob_err_q;
`else
  assign addr_ok         = '1;
  assign disp_ok         = 1'b1;
  assign bus.oob_err_out = 1'b0;
`endif

  // The fill sequencer owns port A while filling; engine writes only land in RUN.
  always_comb begin
    for (int i = 0; i < NUM_DIRS; i++) begin
      lane_addr[i]  = bus.eng_addr_in[i];
      lane_wdata[i] = bus.eng_data_in[i];
      lane_we[i]    = 1'b0;
      if (state == ST_INIT) begin
        lane_addr[i]  = fill_cnt;
        lane_wdata[i] = init_weight(i, INIT_CENTER, INIT_AXIS, INIT_DIAG);
        lane_we[i]    = 1'b1;
      end else if (state == ST_RUN) begin
        lane_we[i] = bus.eng_we_in && addr_ok[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_DIRS; g++) begin : g_lane
    pop_bram_lane #(
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_lane (
      .clk     (clk_in),
      .rst     (rst_in),
      .a_we    (lane_we[g]),
      .a_addr  (lane_addr[g]),
      .a_wdata (lane_wdata[g]),
      .a_rdata (lane_a_rdata[g]),
      .b_addr  (bus.disp_addr_in),
      .b_rdata (lane_b_rdata[g])
    );
  end

  assign disp_req = bus.disp_valid_in && (state == ST_RUN) && disp_ok;

  always_comb begin
    dens_sum = '0;
    for (int i = 0; i < NUM_DIRS; i++)
      dens_sum = dens_sum + DENS_W'(lane_b_rdata[i]);
  end

  // Third display stage registers the populations alongside their density sum.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      disp_vld_pipe <= '0;
      disp_valid_q  <= 1'b0;
      disp_data_q   <= '0;
      disp_dens_q   <= '0;
    end else begin
      disp_vld_pipe <= {disp_vld_pipe[0], disp_req};
      disp_valid_q  <= disp_vld_pipe[1];
      if (disp_vld_pipe[1]) begin
        disp_data_q <= lane_b_rdata;
        disp_dens_q <= dens_sum;
      end
    end
  end

  assign bus.init_busy_out    = init_busy_q;
  assign bus.init_done_out    = init_done_q;
  assign bus.eng_data_out     = lane_a_rdata;
  assign bus.disp_valid_out   = disp_valid_q;
  assign bus.disp_data_out    = disp_data_q;
  assign bus.disp_density_out = disp_dens_q;

endmodule
`default_nettype wire

// File: tb/tb_population_mem.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_population_mem: table-driven and randomized check of population_mem on   |
// | a reduced 16x10 lattice against an array-based reference model.             |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_population_mem;
  import lbm_pkg::*;

  localparam int H     = 16;
  localparam int V     = 10;
  localparam int DEPTH = H * V;
  localparam int AW    = $clog2(DEPTH);
  localparam int N_RND = 400;

  logic clk_in = 1'b0;
  logic rst_in;

  population_mem_if #(.AW(AW)) bus ();

  population_mem #(
    .HPIXELS (H),
    .VPIXELS (V)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [AW-1:0] addr;
    pop_vec_t      data;
    logic [11:0]   dens;
  } disp_vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    base;
    pop_vec_t      exp;
  } pa_vec_t;

  int        n_checks = 0;
  int        n_fail   = 0;
  logic [7:0] model [NUM_DIRS][DEPTH];
  disp_vec_t dtab [3];
  pa_vec_t   ptab [4];

  pop_vec_t    ha [N_RND+3];
  pop_vec_t    hb [N_RND+3];
  logic        hv [N_RND+3];
  logic [11:0] hd [N_RND+3];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic pop_vec_t init_vec();
    pop_vec_t v;
    v[0] = 8'd114;
    for (int l = 1; l <= 4; l++) v[l] = 8'd28;
    for (int l = 5; l < NUM_DIRS; l++) v[l] = 8'd7;
    return v;
  endfunction

  function automatic pop_vec_t model_at(input int a);
    pop_vec_t v;
    for (int l = 0; l < NUM_DIRS; l++) v[l] = model[l][a];
    return v;
  endfunction

  task automatic set_all_addr(input int a);
    for (int l = 0; l < NUM_DIRS; l++) bus.eng_addr_in[l] = AW'(a);
  endtask

  task automatic set_all_data(input logic [7:0] d);
    for (int l = 0; l < NUM_DIRS; l++) bus.eng_data_in[l] = d;
  endtask

  task automatic run_init(input bit poke_start);
    int busy_n = 0;
    int done_n = 0;
    int done_at = -1;
    pop_vec_t iv;
    bus.init_start_in = 1'b1;
    tick();
    bus.init_start_in = 1'b0;
    for (int k = 0; k < DEPTH + 8; k++) begin
      if (bus.init_busy_out) busy_n++;
      if (bus.init_done_out) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      bus.init_start_in = poke_start && (k == DEPTH / 2);
      tick();
    end
    bus.init_start_in = 1'b0;
    check("init_busy_cycles", busy_n, DEPTH);
    check("init_done_pulses", done_n, 1);
    check("init_done_timing", done_at, DEPTH);
    iv = init_vec();
    for (int l = 0; l < NUM_DIRS; l++)
      for (int a = 0; a < DEPTH; a++) model[l][a] = iv[l];
  endtask

  task automatic disp_check(input disp_vec_t dv);
    bus.disp_addr_in  = dv.addr;
    bus.disp_valid_in = 1'b1;
    tick();
    bus.disp_valid_in = 1'b0;
    tick();
    check("disp_latency_early", bus.disp_valid_out, 1'b0);
    tick();
    check("disp_valid", bus.disp_valid_out, 1'b1);
    check("disp_data", bus.disp_data_out, dv.data);
    check("disp_density", bus.disp_density_out, dv.dens);
  endtask

  task automatic pa_apply(input pa_vec_t pv);
    pop_vec_t old_v = model_at(int'(pv.addr));
    set_all_addr(int'(pv.addr));
    for (int l = 0; l < NUM_DIRS; l++) bus.eng_data_in[l] = pv.base + 8'(l);
    bus.eng_we_in = 1'b1;
    tick();
    bus.eng_we_in = 1'b0;
    tick();
    check("pa_read_first", bus.eng_data_out, old_v);
    tick();
    check("pa_readback", bus.eng_data_out, pv.exp);
    for (int l = 0; l < NUM_DIRS; l++) model[l][pv.addr] = pv.exp[l];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pop_vec_t ev;
    logic [AW-1:0] ra [NUM_DIRS];
    pop_vec_t rd;
    logic rwe, rdv;
    logic [AW-1:0] rda;
    int sum;
    logic exp_v;

    dtab[0] = '{addr: AW'(0),         data: 72'h07_07_07_07_1C_1C_1C_1C_72, dens: 12'd254};
    dtab[1] = '{addr: AW'(DEPTH - 1), data: 72'h07_07_07_07_1C_1C_1C_1C_72, dens: 12'd254};
    dtab[2] = '{addr: AW'(83),        data: 72'h07_07_07_07_1C_1C_1C_1C_72, dens: 12'd254};

    ptab[0] = '{addr: AW'(5),         base: 8'd10,  exp: 72'h12_11_10_0F_0E_0D_0C_0B_0A};
    ptab[1] = '{addr: AW'(9),         base: 8'd100, exp: 72'h6C_6B_6A_69_68_67_66_65_64};
    ptab[2] = '{addr: AW'(DEPTH - 1), base: 8'd200, exp: 72'hD0_CF_CE_CD_CC_CB_CA_C9_C8};
    ptab[3] = '{addr: AW'(0),         base: 8'd0,   exp: 72'h08_07_06_05_04_03_02_01_00};

    rst_in            = 1'b1;
    bus.init_start_in = 1'b0;
    bus.eng_we_in     = 1'b0;
    bus.disp_valid_in = 1'b0;
    bus.disp_addr_in  = '0;
    set_all_addr(0);
    set_all_data(8'h00);

    repeat (3) tick();
    check("rst_busy", bus.init_busy_out, 1'b0);
    check("rst_done", bus.init_done_out, 1'b0);
    check("rst_disp_valid", bus.disp_valid_out, 1'b0);
    check("rst_oob", bus.oob_err_out, 1'b0);
    check("rst_disp_data", bus.disp_data_out, 72'h0);
    check("rst_density", bus.disp_density_out, 12'h0);
    check("rst_eng_data", bus.eng_data_out, 72'h0);
    rst_in = 1'b0;
    tick();
    check("idle_no_busy", bus.init_busy_out, 1'b0);

    run_init(1'b0);
    for (int i = 0; i < 3; i++) disp_check(dtab[i]);
    for (int i = 0; i < 4; i++) pa_apply(ptab[i]);

    // Same-cycle write and read at address 7: lane 1 returns the old axis weight.
    set_all_addr(7);
    set_all_data(8'hAA);
    bus.eng_we_in = 1'b1;
    tick();
    bus.eng_we_in = 1'b0;
    tick();
    check("rw_same_cycle_old", bus.eng_data_out[1], 8'd28);
    tick();
    check("rw_next_cycle_new", bus.eng_data_out[1], 8'hAA);
    for (int l = 0; l < NUM_DIRS; l++) model[l][7] = 8'hAA;

    for (int k = 0; k < 4; k++) begin
      set_all_addr(20 + k);
      set_all_data(8'hFF);
      bus.eng_we_in = 1'b1;
      tick();
      for (int l = 0; l < NUM_DIRS; l++) model[l][20 + k] = 8'hFF;
    end
    bus.eng_we_in = 1'b0;

    for (int k = 0; k < 9; k++) begin
      exp_v = (k >= 3) && (k < 7);
      check("burst_valid", bus.disp_valid_out, exp_v);
      if (exp_v) begin
        check("burst_density", bus.disp_density_out, 12'd2295);
        check("burst_data", bus.disp_data_out, {9{8'hFF}});
      end
      bus.disp_valid_in = (k < 4);
      bus.disp_addr_in  = AW'(20 + k);
      tick();
    end
    bus.disp_valid_in = 1'b0;

    // Randomized traffic against the reference array and per-cycle expectation history.
    for (int k = 0; k < N_RND + 3; k++) begin
      if (k >= 2) check("rnd_eng_data", bus.eng_data_out, ha[k-2]);
      if (k >= 3) begin
        check("rnd_disp_valid", bus.disp_valid_out, hv[k-3]);
        if (hv[k-3]) begin
          check("rnd_disp_data", bus.disp_data_out, hb[k-3]);
          check("rnd_disp_density", bus.disp_density_out, hd[k-3]);
        end
      end
      if (k < N_RND) begin
        for (int l = 0; l < NUM_DIRS; l++) begin
          ra[l] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                               : AW'($urandom_range(0, 15));
          rd[l] = 8'($urandom);
        end
        rwe = 1'($urandom_range(0, 1));
        rdv = 1'($urandom_range(0, 1));
        rda = AW'($urandom_range(0, 15));
      end else begin
        rwe = 1'b0;
        rdv = 1'b0;
      end
      for (int l = 0; l < NUM_DIRS; l++) begin
        bus.eng_addr_in[l] = ra[l];
        bus.eng_data_in[l] = rd[l];
      end
      bus.eng_we_in     = rwe;
      bus.disp_valid_in = rdv;
      bus.disp_addr_in  = rda;
      sum = 0;
      for (int l = 0; l < NUM_DIRS; l++) begin
        ha[k][l] = model[l][ra[l]];
        hb[k][l] = model[l][rda];
        sum += int'(model[l][rda]);
      end
      hv[k] = rdv;
      hd[k] = 12'(sum);
      if (rwe)
        for (int l = 0; l < NUM_DIRS; l++) model[l][ra[l]] = rd[l];
      tick();
    end
    bus.eng_we_in     = 1'b0;
    bus.disp_valid_in = 1'b0;

    // Reset in the middle of a fill.
    bus.init_start_in = 1'b1;
    tick();
    bus.init_start_in = 1'b0;
    repeat (DEPTH / 2) tick();
    check("midinit_busy", bus.init_busy_out, 1'b1);
    #3 rst_in = 1'b1;
    #1;
    check("midrst_busy", bus.init_busy_out, 1'b0);
    check("midrst_done", bus.init_done_out, 1'b0);
    check("midrst_disp_valid", bus.disp_valid_out, 1'b0);
    check("midrst_eng_data", bus.eng_data_out, 72'h0);
    check("midrst_disp_data", bus.disp_data_out, 72'h0);
    check("midrst_density", bus.disp_density_out, 12'h0);
    tick();
    rst_in = 1'b0;
    tick();
    for (int k = 0; k < 9; k++) begin
      check("idle_disp_dropped", bus.disp_valid_out, 1'b0);
      check("idle_busy_low", bus.init_busy_out, 1'b0);
      bus.disp_valid_in = (k < 6);
      bus.disp_addr_in  = AW'(k);
      bus.eng_we_in     = (k < 6);
      tick();
    end
    bus.disp_valid_in = 1'b0;
    bus.eng_we_in     = 1'b0;
    set_all_addr(0);

    run_init(1'b1);
    for (int i = 0; i < 3; i++) disp_check(dtab[i]);

`ifdef POP_MEM_OOB_CHECK_EN
    check("oob_clear", bus.oob_err_out, 1'b0);
    set_all_addr(40);
    bus.eng_addr_in[3] = AW'(DEPTH);
    set_all_data(8'h55);
    bus.eng_we_in = 1'b1;
    tick();
    bus.eng_we_in = 1'b0;
    check("oob_set", bus.oob_err_out, 1'b1);
    set_all_addr(40);
    tick();
    tick();
    ev = {9{8'h55}};
    ev[3] = model[3][40];
    check("oob_lane_suppressed", bus.eng_data_out, ev);
    for (int l = 0; l < NUM_DIRS; l++) if (l != 3) model[l][40] = 8'h55;
    bus.disp_addr_in  = AW'(DEPTH + 1);
    bus.disp_valid_in = 1'b1;
    tick();
    bus.disp_valid_in = 1'b0;
    tick();
    tick();
    check("oob_disp_no_resp", bus.disp_valid_out, 1'b0);
    repeat (4) tick();
    check("oob_sticky", bus.oob_err_out, 1'b1);
`else
    ev = '0;
    for (int k = 0; k < 4; k++) begin
      check("oob_tied_low", bus.oob_err_out, 1'b0);
      tick();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/population_mem.md
Name: population_mem

Overview:
- Memory-side responder for the lattice Boltzmann population store: nine per-direction lanes (D2Q9) of HPIXELS*VPIXELS x 8-bit cells.
- Port A serves the streaming/collision engines: per-lane address, write data and shared write enable, with fixed-latency read data back.
- Port B is a read-only display port returning all nine populations and their density sum.
- An init sequencer fills every cell with equilibrium weights before a run.

Parameters:
- HPIXELS, 320, lattice width in cells.
- VPIXELS, 180, lattice height in cells.
- INIT_CENTER, 114, init value for lane 0 (4/9 scaled to 8 bits).
- INIT_AXIS, 28, init value for lanes 1-4 (1/9).
- INIT_DIAG, 7, init value for lanes 5-8 (1/36).
- Derived locals: DEPTH = HPIXELS*VPIXELS; AW = $clog2(DEPTH).

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-high reset.
- init_start_in  in  1  pulse; begin fill (ignored unless IDLE or RUN).
- init_busy_out  out  1  high while filling.
- init_done_out  out  1  one-cycle pulse when fill completes.
- eng_addr_in  in  [8:0][AW-1:0]  per-lane port-A address.
- eng_data_in  in  [8:0][7:0]  per-lane write data.
- eng_we_in  in  1  write all nine lanes at their addresses this cycle.
- eng_data_out  out  [8:0][7:0]  per-lane read data.
- disp_valid_in  in  1  display read request.
- disp_addr_in  in  [AW-1:0]  display cell address (same for all lanes).
- disp_valid_out  out  1  display response valid.
- disp_data_out  out  [8:0][7:0]  nine populations of the requested cell.
- disp_density_out  out  [11:0]  sum of the nine populations.
- oob_err_out  out  1  sticky out-of-range error (see Optional Feature).

Behaviour:
- FSM states: IDLE (after reset), INIT, RUN.
  - IDLE -> INIT on init_start_in.
  - INIT -> RUN when the fill counter writes address DEPTH-1.
  - RUN -> INIT on init_start_in.
  - No other transitions.
- INIT:
  - Counter runs 0..DEPTH-1, one address per cycle.
  - All lanes are written each cycle: lane 0 gets INIT_CENTER, lanes 1-4 get INIT_AXIS, lanes 5-8 get INIT_DIAG.
  - init_busy_out=1 throughout.
  - init_done_out pulses the cycle after the final write, coincident with entering RUN.
- Port A:
  - Active only in RUN. In IDLE/INIT, eng_we_in is ignored.
  - Reads are unconditional: address at cycle t gives eng_data_out at t+2.
  - Read-first: if the same lane/address is written in the same cycle, the old value is returned.
  - A write at t is visible to reads issued at t+1 or later.
- Port B:
  - disp_valid_in accepted only in RUN; dropped in IDLE/INIT.
  - Request at t gives disp_valid_out, disp_data_out and disp_density_out at t+3.
  - Density is computed as a registered adder tree, full width, no saturation (max 9*255=2295 fits 12 bits).
  - Fully pipelined: back-to-back requests give back-to-back responses.
  - Requests dropped by INIT produce no response.
- Port A and port B never conflict; port B read-during-port-A-write to the same cell returns old data.
- Reset (async, any state, including mid-INIT):
  - State IDLE, fill counter 0.
  - init_busy_out, init_done_out, disp_valid_out and oob_err_out all 0.
  - disp_data_out, disp_density_out and eng_data_out all 0.
  - Memory contents are not cleared.
  - In-flight pipeline valids are flushed.
- init_start_in during INIT is ignored; the fill is not restarted.

Optional Feature:
- POP_MEM_OOB_CHECK_EN defined:
  - A port-A write to any lane address >= DEPTH is suppressed for that lane only; other lanes still write.
  - The same applies to a display request with disp_addr_in >= DEPTH: no response is issued.
  - Either event sets oob_err_out the next cycle; it stays set until reset.
- Not defined: addresses are passed to the memories unchecked (out-of-range behaviour undefined) and oob_err_out is tied 0.

Decomposition:
- Package lbm_pkg holds:
  - NUM_DIRS=9, POP_W=8, DENS_W=12.
  - Direction enum: DIR_C, DIR_E, DIR_N, DIR_W, DIR_S, DIR_NE, DIR_NW, DIR_SW, DIR_SE.
  - Default weight constants.
  - A typedef for the [8:0][7:0] population vector.
- Sub-module pop_bram_lane: one true-dual-port 8-bit lane.
  - Port A read/write, port B read-only.
  - Read-first, 2-cycle registered read.
  - Instantiated nine times in a generate loop.

Test Plan:
- Reset, pulse init_start_in -> init_busy_out high for exactly DEPTH cycles, then init_done_out pulses once. Display reads of addr 0 and DEPTH-1 return {114, 28x4, 7x4} with density 254.
- RUN: write eng_data_in lane i = 10+i at address 5 on all lanes; then read address 5 -> eng_data_out lane i = 10+i exactly 2 cycles after the read address.
- Same-cycle write 0xAA and read at address 7 (old value 28 on lane 1) -> lane 1 returns 28; a read one cycle later returns 0xAA.
- Display burst of 4 consecutive addresses during RUN -> 4 consecutive disp_valid_out cycles starting 3 cycles later. All lanes 255 -> density 2295.
- Assert rst_in mid-INIT (counter ~DEPTH/2) -> init_busy_out drops immediately; state IDLE; disp_valid_in ignored until the next init completes.
- With POP_MEM_OOB_CHECK_EN: write lane 3 address DEPTH -> lane 3 unchanged, other lanes written, oob_err_out=1 next cycle and sticky. Without the macro: oob_err_out stays 0.
